// File: rtl/mem_resp_pkg.sv
// Shared constants, halt-state encoding and a byte-select helper for the
// memory-bus responder.
package mem_resp_pkg;

  // I/O window select on mem_a[17:16] and the two decoded I/O registers
  localparam logic [1:0]  IO_SEL  = 2'b11;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PUSH = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } halt_state_e;

  // Pick byte idx (0 = least significant) out of a 32-bit word
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/resp_tx_fifo.sv
// Transmit FIFO for the responder's UART path. Push and pop may occur in the
// same cycle, including when full (the pop frees the slot first). The head
// entry is presented on registered outputs so the UART sees a clean
// valid/data pair; a byte pushed into an empty FIFO appears one cycle later.
module resp_tx_fifo
  import mem_resp_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [7:0]                i_push_data,
  input  logic                      i_pop,
  output logic                      o_push_drop,
  output logic [$clog2(TX_DEPTH):0] o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_head_valid,
  output logic [7:0]                o_head_data
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

  logic [7:0]    r_mem [TX_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_valid;
  logic [7:0]    r_head_data;

  logic          w_pop;
  logic          w_push_ok;
  logic [PW-1:0] w_rd_ptr_d;
  logic [CW-1:0] w_count_d;
  logic [7:0]    w_head_d;

  // Accept/pop decisions and the next head entry
  always_comb begin
    w_pop      = i_pop && (r_count != '0);
    w_push_ok  = i_push && ((r_count != DEPTH_C) || w_pop);
    w_rd_ptr_d = r_rd_ptr + PW'(w_pop);
    w_count_d  = r_count + CW'(w_push_ok) - CW'(w_pop);
    w_head_d   = 8'h00;
    if (w_count_d != '0) begin
      // The new head is the byte being written this cycle only when it is
      // the sole entry left after the update.
      if (w_push_ok && (w_rd_ptr_d == r_wr_ptr)) begin
        w_head_d = i_push_data;
      end else begin
        w_head_d = r_mem[w_rd_ptr_d];
      end
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers, occupancy and registered head outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= 8'h00;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr     <= w_rd_ptr_d;
      r_count      <= w_count_d;
      r_head_valid <= (w_count_d != '0);
      r_head_data  <= w_head_d;
    end
  end

  assign o_push_drop  = i_push && !w_push_ok;
  assign o_count      = r_count;
  assign o_full       = (r_count == DEPTH_C);
  assign o_empty      = (r_count == '0);
  assign o_head_valid = r_head_valid;
  assign o_head_data  = r_head_data;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU byte bus: RAM, UART TX/RX window at
// 0x30000, cycle counter and program-stop at 0x30004. Every cycle is a bus
// access: mem_wr=1 writes, mem_wr=0 reads.
// Optional feature macro: RESP_RX_EN adds the rx_* ports and lets reads of
// 0x30000 consume received bytes; without it those reads return 0x00.
module mem_bus_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
`ifdef RESP_RX_EN
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
`endif
  output logic        program_halt
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] NEAR_FULL = CW'(TX_DEPTH - 2);

  logic [7:0]  r_ram [2**ADDR_WIDTH];
  logic [7:0]  r_bus_dout;
  logic [31:0] r_cycle;
  logic [31:0] r_snap;
  logic        r_tx_overflow;
  halt_state_e r_state;
  logic        r_program_halt;

  logic          w_io;
  logic          w_uart;
  logic          w_clk_reg;
  logic          w_wr_ok;
  logic          w_ram_we;
  logic          w_user_push;
  logic          w_halt_req;
  logic          w_halt_push;
  logic          w_push;
  logic [7:0]    w_push_data;
  logic          w_pop;
  logic          w_push_drop;
  logic [CW-1:0] w_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_uart_byte;
  logic [7:0]    w_rd_byte;
  logic          w_snap_latch;

  // Address decode and write qualification
  always_comb begin
    w_io         = (mem_a[17:16] == IO_SEL);
    w_uart       = w_io && (mem_a[17:0] == IO_UART);
    w_clk_reg    = w_io && (mem_a[17:2] == IO_CLK[17:2]);
    w_wr_ok      = mem_wr && (r_state != HALTED);
    w_ram_we     = w_wr_ok && !w_io;
    w_user_push  = w_wr_ok && w_uart && (bus_din != 8'h00);
    w_halt_req   = w_wr_ok && w_io && (mem_a[17:0] == IO_CLK);
    w_snap_latch = !mem_wr && w_clk_reg && (mem_a[1:0] == 2'b00);
    // A CPU byte arriving during HALT_PUSH goes first so the terminator stays last
    w_halt_push  = (r_state == HALT_PUSH) && !w_user_push && !w_fifo_full;
    w_push       = w_user_push || w_halt_push;
    w_push_data  = w_halt_push ? 8'h00 : bus_din;
    w_pop        = tx_valid && tx_ready;
  end

`ifdef RESP_RX_EN
  assign w_uart_byte = rx_valid ? rx_data : 8'h00;
  // Consume pulse comes straight from decode; held off while reset is asserted
  assign rx_ready    = rst_in && !mem_wr && w_uart && rx_valid;
`else
  assign w_uart_byte = 8'h00;
`endif

  // Read-data mux across RAM and the I/O registers
  always_comb begin
    w_rd_byte = 8'h00;
    if (!w_io) begin
      w_rd_byte = r_ram[mem_a[ADDR_WIDTH-1:0]];
    end else if (w_uart) begin
      w_rd_byte = w_uart_byte;
    end else if (w_clk_reg) begin
      // Byte 0 returns the value being latched this cycle
      w_rd_byte = w_snap_latch ? r_cycle[7:0] : byte_sel(r_snap, mem_a[1:0]);
    end
  end

  resp_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk        (clk_in),
    .i_rst_n      (rst_in),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .o_push_drop  (w_push_drop),
    .o_count      (w_count),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head_valid (tx_valid),
    .o_head_data  (tx_data)
  );

  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      r_ram[mem_a[ADDR_WIDTH-1:0]] <= bus_din;
    end
  end

  // Registered read data, held across write cycles
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_bus_dout <= 8'h00;
    end else if (!mem_wr) begin
      r_bus_dout <= w_rd_byte;
    end
  end

  // Free-running cycle counter (frozen once halted) and its read snapshot
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cycle <= 32'd0;
      r_snap  <= 32'd0;
    end else begin
      if (r_state != HALTED) begin
        r_cycle <= r_cycle + 32'd1;
      end
      if (w_snap_latch) begin
        r_snap <= r_cycle;
      end
    end
  end

  // Sticky record of any TX byte lost to a full FIFO
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_overflow <= 1'b0;
    end else if (w_push_drop) begin
      r_tx_overflow <= 1'b1;
    end
  end

  // Halt sequencing: queue terminator, wait for TX to drain, then stop
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= RUN;
      r_program_halt <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_halt_req) begin
            r_state <= HALT_PUSH;
          end
        end
        HALT_PUSH: begin
          if (w_halt_push) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_fifo_empty && !w_push) begin
            r_state        <= HALTED;
            r_program_halt <= 1'b1;
          end
        end
        HALTED: begin
          r_program_halt <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Back-pressure leaves headroom for one write already in flight upstream
  assign io_buffer_full = (r_state != RUN) || (w_count >= NEAR_FULL);
  assign bus_dout       = r_bus_dout;
  assign program_halt   = r_program_halt;

  // Upper address bits are not decoded; overflow flag is observation-only
  logic w_unused;
  assign w_unused = ^{mem_a[31:18], r_tx_overflow};

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder.
module tb_mem_bus_responder;
  import mem_resp_pkg::*;

  localparam logic [31:0] A_UART = 32'h0003_0000;
  localparam logic [31:0] A_CLK  = 32'h0003_0004;
  localparam logic [31:0] A_IDLE = 32'h0003_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_a = A_IDLE;
  logic        mem_wr = 1'b0;
  logic [7:0]  bus_din = 8'h00;
  logic        tx_ready = 1'b0;
  logic [7:0]  bus_dout;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        program_halt;
`ifdef RESP_RX_EN
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  txq [$];
  int unsigned tb_edges;

  mem_bus_responder #(
    .ADDR_WIDTH (17),
    .TX_DEPTH   (16)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .bus_din        (bus_din),
    .bus_dout       (bus_dout),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
`ifdef RESP_RX_EN
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
`endif
    .program_halt   (program_halt)
  );

  always #5 clk = ~clk;

  // Record every byte the UART side accepts
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  // Reference cycle count: edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_edges <= 0;
    else        tb_edges <= tb_edges + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    mem_a = A_IDLE; mem_wr = 1'b0; bus_din = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; bus_din = d;
    tick;
  endtask

  task automatic bus_read(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0; bus_din = 8'h00;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_vec++; if (bus_dout !== 8'h00) begin n_bad++; $display("FAIL rst_bus_dout: got %h want 00", bus_dout); end
    n_vec++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL rst_io_full: got %b want 0", io_buffer_full); end
    n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_vec++; if (program_halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt: got %b want 0", program_halt); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_ram;
    bus_write(32'h10, 8'hA5);
    bus_read(32'h10);
    n_vec++; if (bus_dout !== 8'hA5) begin n_bad++; $display("FAIL ram_raw: got %h want a5", bus_dout); end
    bus_write(32'h1FFFF, 8'h3C);
    n_vec++; if (bus_dout !== 8'hA5) begin n_bad++; $display("FAIL ram_hold: got %h want a5", bus_dout); end
    bus_read(32'h1FFFF);
    n_vec++; if (bus_dout !== 8'h3C) begin n_bad++; $display("FAIL ram_top: got %h want 3c", bus_dout); end
    idle;
    tick;
  endtask

  task automatic test_uart_tx;
    int base;
    base = txq.size();
    tx_ready = 1'b1;
    bus_write(A_UART, 8'h48);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
      n_bad++; $display("FAIL tx_first: got v=%b d=%h want v=1 d=48", tx_valid, tx_data);
    end
    bus_write(A_UART, 8'h69);
    bus_write(A_UART, 8'h00);
    idle;
    repeat (8) tick;
    n_vec++; if (txq.size() != base + 2) begin n_bad++; $display("FAIL tx_count: got %0d want %0d", txq.size() - base, 2); end
    else begin
      n_vec++; if (txq[base] !== 8'h48) begin n_bad++; $display("FAIL tx_byte0: got %h want 48", txq[base]); end
      n_vec++; if (txq[base+1] !== 8'h69) begin n_bad++; $display("FAIL tx_byte1: got %h want 69", txq[base+1]); end
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_back_pressure;
    int base;
    logic [7:0] exp_b;
    base = txq.size();
    tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) bus_write(A_UART, 8'(i));
    n_vec++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL bp_13: got %b want 0", io_buffer_full); end
    bus_write(A_UART, 8'd14);
    n_vec++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL bp_14: got %b want 1", io_buffer_full); end
    bus_write(A_UART, 8'd15);
    bus_write(A_UART, 8'd16);
    n_vec++; if (dut.r_tx_overflow !== 1'b0) begin n_bad++; $display("FAIL bp_no_ovf: got %b want 0", dut.r_tx_overflow); end
    bus_write(A_UART, 8'd17);
    n_vec++; if (dut.r_tx_overflow !== 1'b1) begin n_bad++; $display("FAIL bp_ovf: got %b want 1", dut.r_tx_overflow); end
    // Push and pop together on a full FIFO: both must take effect
    tx_ready = 1'b1;
    bus_write(A_UART, 8'h77);
    idle;
    repeat (24) tick;
    n_vec++; if (txq.size() != base + 17) begin n_bad++; $display("FAIL bp_count: got %0d want 17", txq.size() - base); end
    else begin
      for (int k = 0; k < 17; k++) begin
        exp_b = (k < 16) ? 8'(k + 1) : 8'h77;
        n_vec++; if (txq[base+k] !== exp_b) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", k, txq[base+k], exp_b); end
      end
    end
    n_vec++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL bp_released: got %b want 0", io_buffer_full); end
  endtask

  task automatic test_counter;
    logic [31:0] exp_snap;
    idle;
    repeat (300) tick;
    mem_a = A_CLK; mem_wr = 1'b0;
    exp_snap = tb_edges;
    tick;
    idle;
    n_vec++; if (bus_dout !== exp_snap[7:0]) begin n_bad++; $display("FAIL cnt_b0: got %h want %h", bus_dout, exp_snap[7:0]); end
    repeat (300) tick;
    bus_read(A_CLK + 32'd1);
    n_vec++; if (bus_dout !== exp_snap[15:8]) begin n_bad++; $display("FAIL cnt_b1: got %h want %h", bus_dout, exp_snap[15:8]); end
    bus_read(A_CLK + 32'd2);
    n_vec++; if (bus_dout !== exp_snap[23:16]) begin n_bad++; $display("FAIL cnt_b2: got %h want %h", bus_dout, exp_snap[23:16]); end
    bus_read(A_CLK + 32'd1);
    bus_read(32'h0003_0008);
    n_vec++; if (bus_dout !== 8'h00) begin n_bad++; $display("FAIL io_other: got %h want 00", bus_dout); end
    idle;
    tick;
  endtask

  task automatic test_uart_read;
    bus_write(32'h20, 8'h5A);
    bus_read(32'h20);
    n_vec++; if (bus_dout !== 8'h5A) begin n_bad++; $display("FAIL rd_ram: got %h want 5a", bus_dout); end
`ifdef RESP_RX_EN
    rx_valid = 1'b1; rx_data = 8'hC3;
    mem_a = A_UART; mem_wr = 1'b0;
    #1;
    n_vec++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_pulse: got %b want 1", rx_ready); end
    tick;
    rx_valid = 1'b0;
    n_vec++; if (bus_dout !== 8'hC3) begin n_bad++; $display("FAIL rx_data: got %h want c3", bus_dout); end
    #1;
    n_vec++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_nopulse: got %b want 0", rx_ready); end
`endif
    bus_read(A_UART);
    n_vec++; if (bus_dout !== 8'h00) begin n_bad++; $display("FAIL rd_uart_empty: got %h want 00", bus_dout); end
    idle;
    tick;
  endtask

  task automatic test_halt;
    int base;
    int empty_at;
    int halt_at;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h61; exp_q[1] = 8'h62; exp_q[2] = 8'h63; exp_q[3] = 8'h00;
    base = txq.size();
    empty_at = -1;
    halt_at = -1;
    tx_ready = 1'b0;
    bus_write(A_UART, 8'h61);
    bus_write(A_UART, 8'h62);
    bus_write(A_UART, 8'h63);
    bus_write(A_CLK, 8'h01);
    idle;
    n_vec++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL halt_bp: got %b want 1", io_buffer_full); end
    for (int i = 0; i < 60; i++) begin
      tx_ready = (i % 2 == 0);
      tick;
      if (empty_at < 0 && !tx_valid) empty_at = i;
      if (halt_at < 0 && program_halt) halt_at = i;
    end
    n_vec++; if (empty_at < 0 || halt_at != empty_at + 1) begin
      n_bad++; $display("FAIL halt_latency: got halt@%0d want %0d", halt_at, empty_at + 1);
    end
    n_vec++; if (txq.size() != base + 4) begin n_bad++; $display("FAIL halt_count: got %0d want 4", txq.size() - base); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++; if (txq[base+k] !== exp_q[k]) begin n_bad++; $display("FAIL halt_byte%0d: got %h want %h", k, txq[base+k], exp_q[k]); end
      end
    end
    tx_ready = 1'b1;
    bus_write(A_UART, 8'h5A);
    bus_write(32'h10, 8'hEE);
    idle;
    repeat (4) tick;
    n_vec++; if (txq.size() != base + 4 || tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL halt_tx_ignored: got %0d bytes v=%b want 4 bytes v=0", txq.size() - base, tx_valid);
    end
    bus_read(32'h10);
    n_vec++; if (bus_dout !== 8'hA5) begin n_bad++; $display("FAIL halt_ram: got %h want a5", bus_dout); end
    idle;
    n_vec++; if (program_halt !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got %b want 1", program_halt); end
  endtask

  task automatic test_reset_mid_drain;
    int base;
    // Leave the halted state with a reset pulse between clock edges
    rst_n = 1'b0; #2; rst_n = 1'b1;
    n_vec++; if (dut.r_tx_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", dut.r_tx_overflow); end
    n_vec++; if (program_halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt_clr: got %b want 0", program_halt); end
    tick;
    tx_ready = 1'b0;
    bus_write(A_UART, 8'h31);
    bus_write(A_UART, 8'h32);
    bus_write(A_CLK, 8'h01);
    bus_read(32'h10);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h31 || io_buffer_full !== 1'b1 || bus_dout !== 8'hA5) begin
      n_bad++; $display("FAIL drain_pre: got v=%b d=%h f=%b o=%h want v=1 d=31 f=1 o=a5", tx_valid, tx_data, io_buffer_full, bus_dout);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus_dout !== 8'h00) begin n_bad++; $display("FAIL arst_bus_dout: got %h want 00", bus_dout); end
    n_vec++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL arst_io_full: got %b want 0", io_buffer_full); end
    n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL arst_tx_valid: got %b want 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL arst_tx_data: got %h want 00", tx_data); end
    n_vec++; if (program_halt !== 1'b0) begin n_bad++; $display("FAIL arst_halt: got %b want 0", program_halt); end
    #1;
    rst_n = 1'b1;
    idle;
    tick;
    n_vec++; if (dut.r_state !== RUN) begin n_bad++; $display("FAIL arst_state: got %0d want %0d", dut.r_state, RUN); end
    base = txq.size();
    tx_ready = 1'b1;
    bus_write(A_UART, 8'h41);
    idle;
    repeat (3) tick;
    n_vec++; if (txq.size() != base + 1 || txq[txq.size()-1] !== 8'h41) begin
      n_bad++; $display("FAIL arst_tx: got %0d bytes want 1 byte 41", txq.size() - base);
    end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_uart_tx;
    test_back_pressure;
    test_counter;
    test_uart_read;
    test_halt;
    test_reset_mid_drain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
